adc_scan_sequencer: RTL
=======================

Name: adc_scan_sequencer

Overview:
- Time-multiplexes one 8-bit parallel ADC (ADC0804-style WR/RD/INTR handshake) across NUM_CH finger-sensor channels through an external analog mux.
- Holds the latest sample per channel in a shadow bank.
- Commits the shadow bank to the servo position bus only on a servo-frame boundary, so every PWM divider sees a stable value for a whole 20 ms frame.

Parameters:
- NUM_CH, 5, number of mux channels scanned (1..8).
- CH_W, 3, width of mux_sel.
- SETTLE_CYCLES, 64, clk cycles mux_sel is held before conversion start.
- WR_CYCLES, 8, adc_wr_n low-pulse length.
- RD_CYCLES, 8, adc_rd_n low length; data captured on its last cycle.
- CONV_TIMEOUT, 50000, max clk cycles waiting for adc_intr_n.
- FRAME_CYCLES, 1000000, servo frame period in clk cycles (50 MHz / 50 Hz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; sampled at channel boundaries.
- adc_data  in  8  ADC parallel output.
- adc_intr_n  in  1  ADC end-of-conversion, active low, asynchronous.
- clear_err  in  1  pulse; clears timeout_err.
- adc_wr_n  out  1  conversion start, active low.
- adc_rd_n  out  1  output enable, active low.
- mux_sel  out  CH_W  analog mux channel.
- pos_out  out  NUM_CH*8  committed positions; channel k at bits [8k+7:8k].
- frame_tick  out  1  one-cycle pulse at each frame start.
- pos_valid  out  1  high after the first commit; stays high.
- timeout_err  out  NUM_CH  sticky per-channel timeout flags.

Behaviour:
Clock, reset and synchronisation:
- One clock. Reset is asynchronous, active-low, with synchronous release.
- adc_intr_n passes through a 2-FF synchroniser before use.

Reset values:
- adc_wr_n = 1, adc_rd_n = 1, mux_sel = 0.
- pos_out = 0, shadow bank = 0, pos_valid = 0, timeout_err = 0, frame_tick = 0.
- Frame counter = 0. FSM = IDLE.

Frame counter:
- Free-running 0..FRAME_CYCLES-1 and wraps to 0. Runs regardless of enable.
- frame_tick = 1 on the cycle the count equals FRAME_CYCLES-1.

FSM:
- IDLE: if enable, set ch = 0 and go to SELECT.
- SELECT: drive mux_sel = ch and count SETTLE_CYCLES, then go to START.
- START: adc_wr_n = 0 for WR_CYCLES, then go to WAIT.
- WAIT: wait for the synchronised intr_n to be low, then go to READ.
  - If the wait counter reaches CONV_TIMEOUT first: set timeout_err[ch], leave shadow[ch] unchanged, go to NEXT.
- READ: adc_rd_n = 0 for RD_CYCLES. Capture adc_data into shadow[ch] on the last cycle, then go to NEXT.
- NEXT: adc_rd_n = 1.
  - If ch < NUM_CH-1: ch++ and go to SELECT.
  - Otherwise go to HOLD.
- HOLD: on frame_tick, copy shadow to pos_out in the same cycle, set pos_valid = 1, then go to IDLE. pos_out is updated only here.

Timing and boundaries:
- Commit latency: pos_out changes on the clock edge that ends the frame_tick cycle.
- A frame_tick while the FSM is not in HOLD is ignored; no partial commit. The previous pos_out is held for another frame.
- A scan longer than one frame commits at the next tick after the scan completes.
- enable deasserted mid-scan: the current channel completes through NEXT, then the FSM goes to IDLE without committing. Shadow keeps partial data.
- clear_err and a new timeout on the same cycle: the timeout wins, so the bit stays set.
- Assertion of rst_n mid-conversion: strobes return high immediately (asynchronously).
- adc_wr_n and adc_rd_n are never low simultaneously.
- All counters are sized by $clog2 of their parameter and saturate/reset per state entry.

Test Plan:
- Reset: rst_n low mid-READ -> adc_rd_n = 1 and pos_out = 0 immediately; after release, FSM restarts from IDLE with mux_sel = 0.
- Normal scan: ADC model returns 8'h10+ch, 200 cycles after WR -> mux_sel steps 0..4, each held ≥64 cycles before WR. At the first frame_tick, pos_out = {14,13,12,11,10} (hex) and pos_valid = 1.
- Frame alignment: ADC model changes returned values mid-frame -> pos_out stays constant between frame_tick pulses and updates exactly one cycle after a tick.
- Timeout: channel 2 never asserts intr_n -> timeout_err = 5'b00100 after 50000 cycles. shadow[2] keeps its old value, and the scan continues to ch 3. clear_err with the channel still broken -> the flag is set again on the next scan.
- Enable drop: deassert enable during ch 1 WAIT -> ch 1 completes, FSM goes to IDLE, and pos_out is unchanged at the following tick.
- Strobe rules: assertion over all tests -> adc_wr_n & adc_rd_n never both 0. adc_wr_n low pulse = 8 cycles, and frame_tick period = 1000000 cycles.

Source files
------------

// File: rtl/adc_scan_sequencer_if.sv
// ADC0804-style parallel converter bus plus the analog mux select that feeds it.
// The sequencer uses the master side; an ADC/mux model or wrapper uses the slave side.
interface adc_scan_sequencer_if #(
    parameter int unsigned CH_W = 3
);
    logic [7:0]      adc_data;
    logic            adc_intr_n;
    logic            adc_wr_n;
    logic            adc_rd_n;
    logic [CH_W-1:0] mux_sel;

    modport master (
        input  adc_data,
        input  adc_intr_n,
        output adc_wr_n,
        output adc_rd_n,
        output mux_sel
    );

    modport slave (
        output adc_data,
        output adc_intr_n,
        input  adc_wr_n,
        input  adc_rd_n,
        input  mux_sel
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Scans NUM_CH finger-sensor channels through one shared 8-bit ADC via an external
// analog mux, keeps the newest sample per channel in a shadow bank, and publishes
// the bank to the servo position bus only on a servo-frame boundary so that every
// PWM divider sees one stable value for a whole frame.
module adc_scan_sequencer #(
    parameter int unsigned NUM_CH        = 5,
    parameter int unsigned CH_W          = 3,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned WR_CYCLES     = 8,
    parameter int unsigned RD_CYCLES     = 8,
    parameter int unsigned CONV_TIMEOUT  = 50000,
    parameter int unsigned FRAME_CYCLES  = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear_err,
    adc_scan_sequencer_if.master    adc,
    output logic [NUM_CH*8-1:0]     pos_out,
    output logic                    frame_tick,
    output logic                    pos_valid,
    output logic [NUM_CH-1:0]       timeout_err
);

    // One step counter serves every timed state; it restarts on each state entry,
    // so it only has to be as wide as the longest interval.
    localparam int unsigned MAX_AB   = (SETTLE_CYCLES > WR_CYCLES) ? SETTLE_CYCLES : WR_CYCLES;
    localparam int unsigned MAX_CD   = (RD_CYCLES > CONV_TIMEOUT) ? RD_CYCLES : CONV_TIMEOUT;
    localparam int unsigned STEP_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
    localparam int unsigned FRAME_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_READ,
        S_NEXT,
        S_HOLD
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [STEP_W-1:0]   step;
    logic                wr_n;
    logic                rd_n;
    logic                intr_meta;
    logic                intr_sync;
    logic [FRAME_W-1:0]  frame_cnt;
    logic [7:0]          shadow [NUM_CH];
    logic [NUM_CH*8-1:0] shadow_flat;

    assign adc.adc_wr_n = wr_n;
    assign adc.adc_rd_n = rd_n;
    assign adc.mux_sel  = ch;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign shadow_flat[8*g +: 8] = shadow[g];
    end

    // Bring the converter's asynchronous end-of-conversion into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_meta <= 1'b1;
            intr_sync <= 1'b1;
        end else begin
            intr_meta <= adc.adc_intr_n;
            intr_sync <= intr_meta;
        end
    end

    // Free-running servo frame counter; the tick is registered one count early so
    // it is high exactly while the count sits on its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (frame_cnt == FRAME_W'(FRAME_CYCLES - 1)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
            frame_tick <= (frame_cnt == FRAME_W'(FRAME_CYCLES - 2));
        end
    end

    // Scan sequencer: settle mux, pulse WR, wait for INTR (bounded), pulse RD,
    // then either move to the next channel or park until the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ch          <= '0;
            step        <= '0;
            wr_n        <= 1'b1;
            rd_n        <= 1'b1;
            shadow      <= '{default: '0};
            pos_out     <= '0;
            pos_valid   <= 1'b0;
            timeout_err <= '0;
        end else begin
            // A timeout raised below in the same cycle overrides this clear.
            if (clear_err) begin
                timeout_err <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        ch    <= '0;
                        step  <= '0;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (step == STEP_W'(SETTLE_CYCLES - 1)) begin
                        step  <= '0;
                        wr_n  <= 1'b0;
                        state <= S_START;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_START: begin
                    if (step == STEP_W'(WR_CYCLES - 1)) begin
                        step  <= '0;
                        wr_n  <= 1'b1;
                        state <= S_WAIT;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!intr_sync) begin
                        step  <= '0;
                        rd_n  <= 1'b0;
                        state <= S_READ;
                    end else if (step == STEP_W'(CONV_TIMEOUT - 1)) begin
                        step            <= '0;
                        timeout_err[ch] <= 1'b1;
                        state           <= S_NEXT;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_READ: begin
                    if (step == STEP_W'(RD_CYCLES - 1)) begin
                        step       <= '0;
                        shadow[ch] <= adc.adc_data;
                        rd_n       <= 1'b1;
                        state      <= S_NEXT;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_NEXT: begin
                    step <= '0;
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (ch < CH_W'(NUM_CH - 1)) begin
                        ch    <= ch + CH_W'(1);
                        state <= S_SELECT;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (frame_tick) begin
                        pos_out   <= shadow_flat;
                        pos_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
